pixel_plot_sink: RTL and testbench
==================================

PIXEL_PLOT_SINK -- requirements
Module: pixel_plot_sink

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- SCR_W, 160, screen width in pixels
- SCR_H, 120, screen height in pixels
- FIFO_DEPTH, 4, plot-request buffer entries (power of two)
- BG_COLOUR, 3'b000, colour written by a clear sweep

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock
- resetn, in, 1, reset (see REQ-003)
- plot_valid, in, 1, drawing engine presents a pixel
- plot_ready, out, 1, sink accepts the pixel this cycle
- plot_x, in, 8, pixel column
- plot_y, in, 7, pixel row
- plot_colour, in, 3, RGB pixel colour
- clear_req, in, 1, one-cycle pulse requesting a full-screen clear
- fb_we, out, 1, framebuffer write enable
- fb_addr, out, 15, framebuffer address
- fb_data, out, 3, framebuffer write colour
- busy, out, 1, FIFO non-empty, clear pending, or clear active
- drop_count, out, 8, count of out-of-range pixels discarded

REQ-003 Reset SHALL be resetn, synchronous, active-low; clock SHALL be clk.

Function
REQ-004 A pixel SHALL be accepted only on a rising clk edge where plot_valid=1 and plot_ready=1; it is then pushed into the FIFO.
REQ-005 plot_ready SHALL be the inverse of (FIFO full OR state=CLEAR OR clear pending).
REQ-006 The state machine SHALL have three states:
- IDLE: FIFO empty, no clear pending.
- DRAIN: FIFO non-empty; pop one entry per cycle.
- CLEAR: one address per cycle.
REQ-007 State transitions SHALL be:
- IDLE->DRAIN when the FIFO becomes non-empty.
- DRAIN->IDLE when the FIFO is empty after a pop.
- IDLE or DRAIN->CLEAR when a clear is pending and the FIFO is empty.
- CLEAR->IDLE after address SCR_W*SCR_H-1 is written.
REQ-008 A clear_req pulse in any state SHALL set a pending flag. Pulses while the flag is set or while in CLEAR SHALL be ignored (not queued).
REQ-009 Pixels already in the FIFO when clear_req arrives SHALL be written before the clear starts.
REQ-010 Write timing:
- Each popped in-range entry SHALL produce exactly one registered fb_we=1 cycle, on the cycle after the pop.
- fb_addr SHALL be plot_y*SCR_W+plot_x, computed in 15 bits; with defaults this is (y<<7)+(y<<5)+x.
- fb_data SHALL be the entry colour.
REQ-011 Best-case latency from acceptance at edge N (FIFO empty, not clearing) to fb_we=1 SHALL be 2 cycles (visible after edge N+2).
REQ-012 A popped entry with plot_x>=SCR_W or plot_y>=SCR_H SHALL NOT assert fb_we; drop_count SHALL increment and saturate at 255.
REQ-013 During CLEAR, fb_we SHALL be 1 every cycle, fb_addr SHALL step 0..SCR_W*SCR_H-1 with no gaps, and fb_data SHALL be BG_COLOUR.
REQ-014 FIFO behaviour:
- Simultaneous push and pop on a non-empty FIFO SHALL leave the occupancy unchanged.
- Pointers SHALL wrap modulo FIFO_DEPTH.
- No push SHALL occur when full; no pop SHALL occur when empty.
REQ-015 fb_we SHALL be 0 in every cycle with no write; fb_addr and fb_data are don't-care when fb_we=0.

Reset
REQ-016 While resetn=0 at a clk edge, the block SHALL reset to:
- state IDLE
- FIFO emptied, pointers 0
- clear pending 0, clear address 0
- drop_count 0
- fb_we 0, fb_addr 0, fb_data 0
- plot_ready 1, busy 0 (from the next cycle)
REQ-017 Reset asserted mid-clear or mid-drain SHALL abort immediately; no further fb_we SHALL occur until new requests arrive.

Structure
REQ-018 SCR_W, SCR_H, state encodings and the 15-bit address width SHALL live in the shared game package used by the control, datapath and screen-update logic.
REQ-019 The FIFO SHALL be a separate sub-module, plot_fifo (parameterised depth and width 18, with push, pop, full, empty).

Verification
REQ-020 Single pixel: reset, then push x=5, y=2, colour=3'b101 -> exactly one fb_we pulse with fb_addr=325 and fb_data=5, 2 cycles after acceptance.
REQ-021 Back-pressure: hold plot_valid=1 with distinct pixels for 10 cycles -> plot_ready never drops, 10 writes occur in order, and none are lost or duplicated.
REQ-022 Out-of-range pixels: push (160,0), (0,120), (159,119) -> one write only, at fb_addr 19199; drop_count=2.
REQ-023 Clear ordering: push 3 pixels, then pulse clear_req -> the 3 pixel writes come first, then 19200 consecutive writes of BG_COLOUR at addresses 0..19199; plot_ready=0 throughout; busy falls 1 cycle after the last write.
REQ-024 Reset mid-clear: assert resetn=0 at clear address 1000 -> fb_we=0 from the next edge, drop_count=0, plot_ready=1.
REQ-025 Saturation: push 300 out-of-range pixels -> drop_count holds at 255.

Source files
------------

// File: rtl/pixel_plot_sink_pkg.sv
// Shared game package: screen geometry, framebuffer address width,
// sink state encoding and the plot-request entry layout.
package pixel_plot_sink_pkg;

    localparam int unsigned DEF_SCR_W = 160;
    localparam int unsigned DEF_SCR_H = 120;
    localparam int unsigned ADDR_W    = 15;
    localparam int unsigned ENTRY_W   = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } plot_entry_t;

    // Linear framebuffer address y*w + x, truncated to the address width.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] x,
                                                   input logic [6:0] y,
                                                   input int unsigned w);
        logic [31:0] a;
        a = 32'(y) * w + 32'(x);
        return a[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/pixel_plot_sink_fifo.sv
// Plot-request FIFO. DEPTH must be a power of two so the pointers wrap
// naturally; the extra pointer bit separates full from empty.
module plot_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 18
)(
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // Overflowing pushes and underflowing pops are dropped here.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointer update with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/pixel_plot_sink.sv
// Pixel plot sink: buffers plot requests from the drawing engine, turns
// them into framebuffer writes, and runs full-screen clear sweeps.
module pixel_plot_sink
    import pixel_plot_sink_pkg::*;
#(
    parameter int unsigned SCR_W      = DEF_SCR_W,
    parameter int unsigned SCR_H      = DEF_SCR_H,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [2:0]  BG_COLOUR  = 3'b000
)(
    input  logic              clk,
    input  logic              resetn,
    input  logic              plot_valid,
    output logic              plot_ready,
    input  logic [7:0]        plot_x,
    input  logic [6:0]        plot_y,
    input  logic [2:0]        plot_colour,
    input  logic              clear_req,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_data,
    output logic              busy,
    output logic [7:0]        drop_count
);
    localparam int unsigned       NPIX      = SCR_W * SCR_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    state_t            state, state_nx;
    logic              pending;
    logic [ADDR_W-1:0] clr_addr;
    logic              fifo_full, fifo_empty, push, pop, last_clr, in_range;
    plot_entry_t       wr_entry, rd_entry;

    assign wr_entry   = {plot_x, plot_y, plot_colour};
    assign plot_ready = !(fifo_full || state == ST_CLEAR || pending);
    assign push       = plot_valid && plot_ready;
    assign pop        = (state == ST_DRAIN) && !fifo_empty;
    assign last_clr   = (clr_addr == LAST_ADDR);
    assign in_range   = (32'(rd_entry.x) < SCR_W) && (32'(rd_entry.y) < SCR_H);
    // A write still on the bus keeps busy high so it falls after the last write.
    assign busy       = !fifo_empty || pending || (state == ST_CLEAR) || fb_we;

    plot_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (wr_entry),
        .dout   (rd_entry),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Next state: queued pixels always drain before a pending clear starts.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (pending && fifo_empty) state_nx = ST_CLEAR;
                else if (!fifo_empty)      state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty) state_nx = pending ? ST_CLEAR : ST_IDLE;
            end
            ST_CLEAR: begin
                if (last_clr) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, clear bookkeeping, drop counter and registered write port.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            pending    <= 1'b0;
            clr_addr   <= '0;
            drop_count <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
        end else begin
            state <= state_nx;
            fb_we <= 1'b0;

            // Pending is consumed on entry to CLEAR; extra pulses are not queued.
            if (state_nx == ST_CLEAR && state != ST_CLEAR) pending <= 1'b0;
            else if (clear_req && state != ST_CLEAR)       pending <= 1'b1;

            if (state == ST_CLEAR) begin
                fb_we    <= 1'b1;
                fb_addr  <= clr_addr;
                fb_data  <= BG_COLOUR;
                clr_addr <= last_clr ? '0 : clr_addr + ADDR_W'(1);
            end else if (pop) begin
                if (in_range) begin
                    fb_we   <= 1'b1;
                    fb_addr <= pix_addr(rd_entry.x, rd_entry.y, SCR_W);
                    fb_data <= rd_entry.colour;
                end else if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Self-checking bench for pixel_plot_sink: scenario tasks compare the
// observed framebuffer write stream against a queue-based reference model.
module tb_pixel_plot_sink;
    localparam int W    = 160;
    localparam int H    = 120;
    localparam int NPIX = W * H;
    localparam logic [2:0] BG = 3'b010;

    logic        clk, resetn, plot_valid, plot_ready, clear_req;
    logic [7:0]  plot_x;
    logic [6:0]  plot_y;
    logic [2:0]  plot_colour;
    logic        fb_we, busy;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic [7:0]  drop_count;

    int checks = 0, failures = 0, cyc = 0, m_drops = 0;
    int got_addr[$], got_data[$], got_cyc[$];
    int exp_addr[$], exp_data[$];

    pixel_plot_sink #(.SCR_W(W), .SCR_H(H), .FIFO_DEPTH(4), .BG_COLOUR(BG)) dut (
        .clk(clk), .resetn(resetn), .plot_valid(plot_valid), .plot_ready(plot_ready),
        .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour), .clear_req(clear_req),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .busy(busy),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: records every framebuffer write with its edge number.
    always @(negedge clk) begin
        if (fb_we) begin
            got_addr.push_back(int'(fb_addr));
            got_data.push_back(int'(fb_data));
            got_cyc.push_back(cyc);
        end
    end

    // Reference model of one accepted pixel.
    function automatic void model_accept(input int x, input int y, input int c);
        if (x < W && y < H) begin
            exp_addr.push_back(y * W + x);
            exp_data.push_back(c);
        end else if (m_drops < 255) begin
            m_drops++;
        end
    endfunction

    function automatic void model_clear();
        for (int a = 0; a < NPIX; a++) begin
            exp_addr.push_back(a);
            exp_data.push_back(int'(BG));
        end
    endfunction

    function automatic int first_mismatch();
        int n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++)
            if (got_addr[i] != exp_addr[i] || got_data[i] != exp_data[i]) return i;
        return -1;
    endfunction

    task automatic clear_logs();
        got_addr.delete(); got_data.delete(); got_cyc.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic do_reset();
        resetn = 1'b0; plot_valid = 1'b0; clear_req = 1'b0;
        plot_x = '0; plot_y = '0; plot_colour = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        m_drops = 0;
        clear_logs();
    endtask

    // Present one pixel (called at a negedge); returns the acceptance edge.
    task automatic send_pix(input int x, input int y, input int c, output int acc);
        int n = 0;
        plot_valid = 1'b1; plot_x = 8'(x); plot_y = 7'(y); plot_colour = 3'(c);
        while (!plot_ready) begin
            @(negedge clk);
            n++;
            if (n > 30000) begin
                $display("FAIL send_timeout: plot_ready stayed 0 for %0d cycles", n);
                $fatal(1, "send timeout");
            end
        end
        @(negedge clk);
        acc = cyc;
        plot_valid = 1'b0;
        model_accept(x, y, c);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy) begin
            @(negedge clk);
            n++;
            if (n > 30000) begin
                $display("FAIL idle_timeout: busy stayed 1 for %0d cycles", n);
                $fatal(1, "idle timeout");
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (fb_we !== 1'b0)       begin failures++; $display("FAIL rst_fb_we got=%b want=0", fb_we); end
        checks++; if (fb_addr !== 15'd0)    begin failures++; $display("FAIL rst_fb_addr got=%0d want=0", fb_addr); end
        checks++; if (fb_data !== 3'd0)     begin failures++; $display("FAIL rst_fb_data got=%0d want=0", fb_data); end
        checks++; if (plot_ready !== 1'b1)  begin failures++; $display("FAIL rst_ready got=%b want=1", plot_ready); end
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
        checks++; if (drop_count !== 8'd0)  begin failures++; $display("FAIL rst_drops got=%0d want=0", drop_count); end
    endtask

    task automatic test_single();
        int acc;
        do_reset();
        send_pix(5, 2, 3'b101, acc);
        wait_idle();
        checks++; if (got_addr.size() != 1) begin failures++; $display("FAIL single_count got=%0d want=1", got_addr.size()); end
        if (got_addr.size() >= 1) begin
            checks++; if (got_addr[0] != 325) begin failures++; $display("FAIL single_addr got=%0d want=325", got_addr[0]); end
            checks++; if (got_data[0] != 5)   begin failures++; $display("FAIL single_data got=%0d want=5", got_data[0]); end
            checks++; if (got_cyc[0] != acc + 2) begin failures++; $display("FAIL single_latency got=%0d want=%0d", got_cyc[0] - acc, 2); end
        end
    endtask

    task automatic test_back_to_back();
        int acc, drops = 0, gaps = 0, m;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (!plot_ready) drops++;
            send_pix(int'($urandom_range(0, W - 1)), i * 11, int'($urandom_range(0, 7)), acc);
        end
        wait_idle();
        checks++; if (drops != 0) begin failures++; $display("FAIL b2b_ready_drops got=%0d want=0", drops); end
        checks++; if (got_addr.size() != 10) begin failures++; $display("FAIL b2b_count got=%0d want=10", got_addr.size()); end
        m = first_mismatch();
        checks++; if (m != -1) begin failures++; $display("FAIL b2b_order idx=%0d got=%0d/%0d want=%0d/%0d", m, got_addr[m], got_data[m], exp_addr[m], exp_data[m]); end
        for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] != got_cyc[0] + i) gaps++;
        checks++; if (gaps != 0) begin failures++; $display("FAIL b2b_gaps got=%0d want=0", gaps); end
    endtask

    task automatic test_out_of_range();
        int acc;
        do_reset();
        send_pix(160, 0, 1, acc);
        send_pix(0, 120, 2, acc);
        send_pix(159, 119, 6, acc);
        wait_idle();
        checks++; if (got_addr.size() != 1) begin failures++; $display("FAIL oor_count got=%0d want=1", got_addr.size()); end
        if (got_addr.size() >= 1) begin
            checks++; if (got_addr[0] != 19199) begin failures++; $display("FAIL oor_addr got=%0d want=19199", got_addr[0]); end
        end
        checks++; if (drop_count !== 8'd2) begin failures++; $display("FAIL oor_drops got=%0d want=2", drop_count); end
    endtask

    task automatic test_random();
        int acc, m;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            send_pix(int'($urandom_range(0, 200)), int'($urandom_range(0, 127)), int'($urandom_range(0, 7)), acc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        checks++; if (got_addr.size() != exp_addr.size()) begin failures++; $display("FAIL rand_count got=%0d want=%0d", got_addr.size(), exp_addr.size()); end
        m = first_mismatch();
        checks++; if (m != -1) begin failures++; $display("FAIL rand_seq idx=%0d got=%0d/%0d want=%0d/%0d", m, got_addr[m], got_data[m], exp_addr[m], exp_data[m]); end
        checks++; if (int'(drop_count) != m_drops) begin failures++; $display("FAIL rand_drops got=%0d want=%0d", drop_count, m_drops); end
    endtask

    task automatic test_clear();
        int acc, m, rdy_bad = 0, fall = -1, gaps = 0;
        do_reset();
        send_pix(1, 1, 1, acc);
        send_pix(2, 3, 4, acc);
        send_pix(159, 0, 7, acc);
        pulse_clear();
        model_clear();
        for (int n = 0; n < 25000; n++) begin
            if (!busy) begin fall = cyc; break; end
            if (plot_ready && !(fb_we && int'(fb_addr) == NPIX - 1)) rdy_bad++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++; if (rdy_bad != 0) begin failures++; $display("FAIL clr_ready got=%0d high cycles want=0", rdy_bad); end
        checks++; if (got_addr.size() != 3 + NPIX) begin failures++; $display("FAIL clr_count got=%0d want=%0d", got_addr.size(), 3 + NPIX); end
        m = first_mismatch();
        checks++; if (m != -1) begin failures++; $display("FAIL clr_seq idx=%0d got=%0d/%0d want=%0d/%0d", m, got_addr[m], got_data[m], exp_addr[m], exp_data[m]); end
        for (int i = 4; i < got_cyc.size(); i++) if (got_cyc[i] != got_cyc[i-1] + 1) gaps++;
        checks++; if (gaps != 0) begin failures++; $display("FAIL clr_gaps got=%0d want=0", gaps); end
        if (got_cyc.size() > 0) begin
            checks++; if (fall != got_cyc[got_cyc.size()-1] + 1) begin failures++; $display("FAIL clr_busy_fall got=%0d want=%0d", fall, got_cyc[got_cyc.size()-1] + 1); end
        end
    endtask

    task automatic test_reset_mid_clear();
        int acc;
        bit found = 1'b0;
        do_reset();
        send_pix(200, 5, 3, acc);
        wait_idle();
        pulse_clear();
        for (int n = 0; n < 3000; n++) begin
            if (fb_we && fb_addr == 15'd1000) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found) begin failures++; $display("FAIL mid_reach got=not_seen want=addr1000"); end
        resetn = 1'b0;
        @(negedge clk);
        checks++; if (fb_we !== 1'b0)      begin failures++; $display("FAIL mid_fb_we got=%b want=0", fb_we); end
        checks++; if (drop_count !== 8'd0) begin failures++; $display("FAIL mid_drops got=%0d want=0", drop_count); end
        checks++; if (plot_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b want=1", plot_ready); end
        resetn = 1'b1;
        clear_logs();
        m_drops = 0;
        repeat (30) @(negedge clk);
        checks++; if (got_addr.size() != 0) begin failures++; $display("FAIL mid_no_writes got=%0d want=0", got_addr.size()); end
    endtask

    task automatic test_saturation();
        int acc;
        do_reset();
        for (int i = 0; i < 300; i++)
            send_pix(int'($urandom_range(W, 255)), int'($urandom_range(0, 127)), int'($urandom_range(0, 7)), acc);
        wait_idle();
        checks++; if (drop_count !== 8'd255) begin failures++; $display("FAIL sat_drops got=%0d want=255 model=%0d", drop_count, m_drops); end
        checks++; if (got_addr.size() != 0) begin failures++; $display("FAIL sat_writes got=%0d want=0", got_addr.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_out_of_range();
        test_random();
        test_clear();
        test_reset_mid_clear();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
